// File: rtl/vm_button_conditioner.sv
// rtl/vm_button_conditioner.sv - synchronise, debounce, auto-repeat and arbitrate the five panel buttons
// Internal bit order: 0 enter, 1 c, 2 u, 3 cima, 4 baixo (lower index wins arbitration).
module vm_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_RATE     = 8,
   parameter int CNT_W           = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic c_raw,
   input  logic u_raw,
   input  logic cima_raw,
   input  logic baixo_raw,
   input  logic enter_raw,
   output logic c,
   output logic u,
   output logic cima,
   output logic baixo,
   output logic enter,
   output logic any_held
);
   localparam int NB = 5;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

   logic [NB-1:0]    raw;
   logic [NB-1:0]    s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
   logic [NB-1:0]    pend_q, pend_d, out_q, out_d;
   logic [CNT_W-1:0] db_cnt_q [NB];
   logic [CNT_W-1:0] db_cnt_d [NB];
   logic [CNT_W-1:0] rep_cnt_q [2];
   logic [CNT_W-1:0] rep_cnt_d [2];
   logic [1:0]       rep_first_q, rep_first_d;
   logic             any_held_q, any_held_d;
   logic [NB-1:0]    press, fall, cand;
   logic [1:0]       rep_ev;

   assign raw = {baixo_raw, cima_raw, u_raw, c_raw, enter_raw};

   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      press    = '0;
      fall     = '0;
      for (int i = 0; i < NB; i++) begin
         db_cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               stable_d[i] = s2_q[i];
               press[i]    = s2_q[i];
               fall[i]     = ~s2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + ONE;
            end
         end
      end

      // Repeat counter idles at zero while released; first period is the delay, then the rate.
      rep_ev = '0;
      for (int j = 0; j < 2; j++) begin
         rep_cnt_d[j]   = '0;
         rep_first_d[j] = 1'b1;
         if (stable_q[3+j] && !fall[3+j]) begin
            if (rep_cnt_q[j] == (rep_first_q[j] ? RD_LAST : RR_LAST)) begin
               rep_ev[j]      = 1'b1;
               rep_first_d[j] = 1'b0;
            end else begin
               rep_cnt_d[j]   = rep_cnt_q[j] + ONE;
               rep_first_d[j] = rep_first_q[j];
            end
         end
      end

      cand       = pend_q | press | {rep_ev, 3'b000};
      out_d      = cand & (~cand + 5'd1);
      pend_d     = cand & ~out_d;
      any_held_d = |stable_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         stable_q    <= '0;
         pend_q      <= '0;
         out_q       <= '0;
         any_held_q  <= 1'b0;
         rep_first_q <= 2'b11;
         for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
         for (int j = 0; j < 2; j++) rep_cnt_q[j] <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         stable_q    <= stable_d;
         pend_q      <= pend_d;
         out_q       <= out_d;
         any_held_q  <= any_held_d;
         rep_first_q <= rep_first_d;
         for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
         for (int j = 0; j < 2; j++) rep_cnt_q[j] <= rep_cnt_d[j];
      end
   end

   assign enter    = out_q[0];
   assign c        = out_q[1];
   assign u        = out_q[2];
   assign cima     = out_q[3];
   assign baixo    = out_q[4];
   assign any_held = any_held_q;
endmodule

// File: tb/tb_vm_button_conditioner.sv
// tb/tb_vm_button_conditioner.sv - scoreboard bench for vm_button_conditioner
// Bit order in this bench: 0 enter, 1 c, 2 u, 3 cima, 4 baixo.
module tb_vm_button_conditioner;
   localparam int DB   = 4;
   localparam int RD   = 16;
   localparam int RR   = 8;
   localparam int MAXE = 4000;
   localparam logic [4:0] EN = 5'b00001, CB = 5'b00010, UB = 5'b00100, CI = 5'b01000, BA = 5'b10000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic c_raw = 1'b0, u_raw = 1'b0, cima_raw = 1'b0, baixo_raw = 1'b0, enter_raw = 1'b0;
   logic c, u, cima, baixo, enter, any_held;

   vm_button_conditioner #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(16)
   ) dut (
      .clock(clock), .reset(reset),
      .c_raw(c_raw), .u_raw(u_raw), .cima_raw(cima_raw), .baixo_raw(baixo_raw), .enter_raw(enter_raw),
      .c(c), .u(u), .cima(cima), .baixo(baixo), .enter(enter), .any_held(any_held)
   );

   always #5 clock = ~clock;

   typedef struct { int cyc; logic [4:0] oh; } exp_t;
   exp_t exp_q[$];
   bit   ah_exp [MAXE];
   bit   r_h    [MAXE][5];
   bit   rst_h  [MAXE];
   bit   st_h   [MAXE][5];
   int   press_e [5];
   bit   pend    [5];
   int   e_next = 0;
   int   total  = 0;
   int   bad    = 0;

   // Synchronised level seen by the debouncer after edge k (two-edge delay, cleared by reset).
   function automatic bit s2_after(input int k, input int b);
      if (k < 1) return 1'b0;
      if (rst_h[k] || rst_h[k-1]) return 1'b0;
      return r_h[k-1][b];
   endfunction

   task automatic model_edge(input int e);
      bit ev [5];
      bit prev, flip, any;
      int d;
      any = 1'b0;
      for (int b = 0; b < 5; b++) begin
         ev[b] = 1'b0;
         prev  = (e > 0) ? st_h[e-1][b] : 1'b0;
         if (rst_h[e]) begin
            st_h[e][b] = 1'b0;
         end else begin
            // Level accepted once the last DB synchronised samples all disagree with it.
            flip = 1'b1;
            for (int k = e - DB + 1; k <= e; k++)
               if (k < 0 || rst_h[k] || s2_after(k - 1, b) == prev) flip = 1'b0;
            st_h[e][b] = flip ? !prev : prev;
            if (flip && !prev) begin
               ev[b]      = 1'b1;
               press_e[b] = e;
            end
            if (b >= 3 && prev && st_h[e][b]) begin
               d = e - press_e[b];
               if (d >= RD && ((d - RD) % RR) == 0) ev[b] = 1'b1;
            end
         end
         any |= st_h[e][b];
      end
      ah_exp[e] = any;
      if (rst_h[e]) begin
         for (int b = 0; b < 5; b++) pend[b] = 1'b0;
      end else begin
         for (int b = 0; b < 5; b++) pend[b] |= ev[b];
         for (int b = 0; b < 5; b++)
            if (pend[b]) begin
               pend[b] = 1'b0;
               exp_q.push_back('{cyc: e, oh: 5'(1) << b});
               break;
            end
      end
   endtask

   task automatic step(input logic [4:0] r, input bit rs);
      if (e_next >= MAXE) begin
         $display("FAIL stimulus_overrun e=%0d limit=%0d", e_next, MAXE);
         $fatal(1);
      end
      {baixo_raw, cima_raw, u_raw, c_raw, enter_raw} = r;
      if (rs && !reset) begin
         reset = 1'b1;
         #1;
         total++;
         if ({baixo, cima, u, c, enter, any_held} !== 6'b0) begin
            bad++;
            $display("FAIL async_reset_drop got=%b exp=000000", {baixo, cima, u, c, enter, any_held});
         end
      end
      reset = rs;
      for (int b = 0; b < 5; b++) r_h[e_next][b] = r[b];
      rst_h[e_next] = rs;
      model_edge(e_next);
      e_next++;
      @(negedge clock);
   endtask

   task automatic hold(input logic [4:0] r, input int n, input bit rs);
      for (int i = 0; i < n; i++) step(r, rs);
   endtask

   int mon_e = 0;
   always @(posedge clock) begin
      logic [4:0] outs, expo;
      #1;
      if (mon_e < e_next) begin
         outs = {baixo, cima, u, c, enter};
         expo = '0;
         if (exp_q.size() > 0 && exp_q[0].cyc == mon_e) begin
            expo = exp_q[0].oh;
            void'(exp_q.pop_front());
         end
         total++;
         if (outs !== expo) begin
            bad++;
            $display("FAIL pulses edge=%0d got=%b exp=%b", mon_e, outs, expo);
         end
         total++;
         if (any_held !== ah_exp[mon_e]) begin
            bad++;
            $display("FAIL any_held edge=%0d got=%b exp=%b", mon_e, any_held, ah_exp[mon_e]);
         end
      end
      mon_e++;
   end

   initial begin
      logic [4:0] lvl;
      hold(5'b0, 3, 1'b1);
      hold(5'b0, 5, 1'b0);
      // single c press
      hold(CB, 10, 1'b0);  hold(5'b0, 15, 1'b0);
      // u glitches then a valid press
      for (int i = 0; i < 12; i++) step((i % 2 == 0) ? UB : 5'b0, 1'b0);
      hold(UB, 3, 1'b0);   hold(5'b0, 10, 1'b0);
      hold(UB, 5, 1'b0);   hold(5'b0, 15, 1'b0);
      // long holds: cima repeats, enter does not
      hold(CI, 36, 1'b0);  hold(5'b0, 15, 1'b0);
      hold(EN, 36, 1'b0);  hold(5'b0, 15, 1'b0);
      // simultaneous presses
      hold(EN | CB | BA, 10, 1'b0); hold(5'b0, 15, 1'b0);
      // reset in the middle of a cima hold
      hold(CI, 10, 1'b0);  hold(CI, 2, 1'b1);
      hold(CI, 30, 1'b0);  hold(5'b0, 15, 1'b0);
      // ten coin presses
      for (int i = 0; i < 10; i++) begin
         hold(CB, 6, 1'b0); hold(5'b0, 6, 1'b0);
      end
      hold(5'b0, 10, 1'b0);
      // random levels with occasional one-cycle glitches and a stray reset
      lvl = '0;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 11) == 0) lvl[b] = ~lvl[b];
         if ($urandom_range(0, 15) == 0)
            step(lvl ^ (5'(1) << $urandom_range(0, 4)), 1'b0);
         else
            step(lvl, (i == 200 || i == 201));
      end
      hold(5'b0, 40, 1'b0);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vm_button_conditioner.md
Name: vm_button_conditioner

Overview:
- Upstream front end of the vending-machine controller. Conditions the five raw panel buttons: c, u, cima, baixo, enter.
- Per button: synchronises, debounces and converts each press into a single-cycle event pulse.
- cima/baixo additionally auto-repeat while held, for menu scrolling.
- An arbiter guarantees at most one event pulse per clock, so the downstream FSM never sees simultaneous commands.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced state before it is accepted (≥1).
- REPEAT_DELAY, 16, cycles from the initial cima/baixo pulse to the first auto-repeat pulse (≥2).
- REPEAT_RATE, 8, cycles between subsequent auto-repeat pulses (≥2).
- CNT_W, 16, width of the internal debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- c_raw  in  1  raw coin button "c", asynchronous, level
- u_raw  in  1  raw coin button "u", asynchronous, level
- cima_raw  in  1  raw menu-up button, asynchronous, level
- baixo_raw  in  1  raw menu-down button, asynchronous, level
- enter_raw  in  1  raw confirm button, asynchronous, level
- c  out  1  one-cycle event pulse
- u  out  1  one-cycle event pulse
- cima  out  1  one-cycle event pulse
- baixo  out  1  one-cycle event pulse
- enter  out  1  one-cycle event pulse
- any_held  out  1  OR of the five debounced levels

Behaviour:
Reset:
- Single clock domain. Reset is asynchronous and active-high.
- On reset: all outputs, synchronisers, debounced levels, counters and pending bits = 0.

Synchroniser:
- Per button, 2-FF synchroniser s1 -> s2.

Debounce (per button):
- s2 == stable: counter <= 0.
- s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
- Otherwise: counter <= counter+1.

Press event:
- Raised when stable goes 0->1, at the same edge stable updates.
- Release (stable 1->0) raises no event.

Latency:
- Let edge N be the first edge sampling raw=1 (held).
- Uncontended pulse is high during the cycle after edge N+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges.

Auto-repeat (cima and baixo only):
- A repeat counter runs while stable=1.
- Repeat events are raised REPEAT_DELAY cycles after the press event, then every REPEAT_RATE cycles.
- Stable falling clears the repeat counter; no repeat event is raised on that edge.
- c, u and enter never repeat.

Arbiter:
- candidate = pending | new_events.
- Priority, highest first: enter, c, u, cima, baixo.
- Output register <= one-hot highest-priority bit of candidate.
- pending <= candidate & ~output.
- Uncontended events pass through with zero added latency.
- A losing event is emitted on a later cycle, in priority order.
- A new event on a channel whose pending bit is already set merges: one pulse total, not two.
- Output pulses are therefore mutually exclusive and each lasts exactly one cycle.

any_held:
- Registered OR of the stable bits; same timing as the stable updates.

Reset mid-operation:
- Outputs drop asynchronously; all state clears.
- A button still held after reset release is a new press: pulse DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.

Glitches:
- Raw glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event and no any_held change.

Test Plan:
(Default parameters; P = cycle of the first pulse.)
1. c_raw high 10 cycles, then low -> exactly one c pulse, 6 edges after the first sampling edge; no other output pulses; any_held high from that edge until the debounced release.
2. u_raw toggling every cycle for 12 cycles, then a high run of 3 cycles, then low -> no u pulse, any_held stays 0. Then u_raw held 5 cycles -> exactly one u pulse.
3. cima_raw held 36 cycles -> cima pulses at P, P+16, P+24, P+32 (4 total), none after release.
   - enter_raw held 36 cycles -> exactly 1 enter pulse.
4. enter_raw, c_raw and baixo_raw rising at the same edge -> enter at P, c at P+1, baixo at P+2; never two outputs high in one cycle.
5. cima_raw held; reset asserted mid-hold for 2 cycles, released with cima_raw still high -> all outputs 0 during reset; exactly one cima pulse 6 edges after the first post-reset sampling edge; repeat timing restarts from that pulse.
6. Ten c presses (high 6 cycles, low 6 cycles each) -> exactly 10 c pulses, one per press, matching the downstream 10-step credit sequence.
